// File: rtl/rotor_seq_if.sv
// Rotor-side handshake bundle: configuration, character strobe, pacing enable and result return.
// The master end is the sequencer and the slave end is the rotor stage.
interface rotor_seq_if;
   logic          r_set;
   logic [31:0]   r_offset;
   logic [31:0]   r_delay;
   logic [207:0]  r_idx;
   logic          r_dec;
   logic          r_valid;
   logic [7:0]    r_din;
   logic          r_en;
   logic          r_rot;
   logic [7:0]    r_dout;
   logic          r_done;

   modport master (
      output r_set, r_offset, r_delay, r_idx, r_dec, r_valid, r_din, r_en, r_rot,
      input  r_dout, r_done
   );

   modport slave (
      input  r_set, r_offset, r_delay, r_idx, r_dec, r_valid, r_din, r_en, r_rot,
      output r_dout, r_done
   );
endinterface

// File: rtl/rotor_seq.sv
// Sequences one host character at a time through a rotor stage: strobe at T+1, enable from T+2, result the cycle after r_done.
// Host output is held under out_ready backpressure; in_ready is only offered in IDLE, so one character is in flight at most.
module rotor_seq #(
   parameter int TIMEOUT = 64,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             cfg_load,
   input  logic [31:0]      cfg_offset,
   input  logic [31:0]      cfg_delay,
   input  logic [207:0]     cfg_table,
   input  logic             cfg_dec,
   output logic             cfg_ack,
   input  logic             in_valid,
   input  logic [7:0]       in_char,
   output logic             in_ready,
   output logic             out_valid,
   output logic [7:0]       out_char,
   input  logic             out_ready,
   output logic             err,
   output logic [CNT_W-1:0] char_cnt,
   rotor_seq_if.master      rot
);

   localparam int WW = $clog2(TIMEOUT);
   localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, CFG, ISSUE, WAIT, OUT} state_t;

   state_t           state, state_n;
   logic [WW-1:0]    wait_cnt, wait_n;
   logic [31:0]      offset_q, offset_n, delay_q, delay_n;
   logic [207:0]     table_q, table_n;
   logic             dec_q, dec_n;
   logic [7:0]       din_q, din_n, out_char_q, out_char_n;
   logic             err_q, err_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic             set_q, valid_q, en_q, ov_q;
   logic             is_letter;

   assign is_letter = (in_char >= 8'd65) && (in_char <= 8'd90);

   always_comb begin
      state_n    = state;
      wait_n     = wait_cnt;
      offset_n   = offset_q;
      delay_n    = delay_q;
      table_n    = table_q;
      dec_n      = dec_q;
      din_n      = din_q;
      out_char_n = out_char_q;
      err_n      = err_q;
      cnt_n      = cnt_q;
      case (state)
         IDLE: begin
            // cfg_load wins over a same-cycle character; in_ready is already low then.
            if (cfg_load) begin
               state_n  = CFG;
               offset_n = cfg_offset;
               delay_n  = cfg_delay;
               table_n  = cfg_table;
               dec_n    = cfg_dec;
            end else if (in_valid) begin
               if (is_letter) begin
                  din_n   = in_char;
                  state_n = ISSUE;
               end else begin
                  out_char_n = in_char;
                  state_n    = OUT;
               end
            end
         end
         CFG:   state_n = IDLE;
         ISSUE: begin
            wait_n  = '0;
            state_n = WAIT;
         end
         WAIT: begin
            // A done arriving on the timeout cycle still delivers the character.
            if (rot.r_done) begin
               out_char_n = rot.r_dout;
               cnt_n      = cnt_q + 1'b1;
               state_n    = OUT;
            end else if (wait_cnt == WAIT_LAST) begin
               err_n   = 1'b1;
               state_n = IDLE;
            end else begin
               wait_n = wait_cnt + 1'b1;
            end
         end
         OUT:     if (out_ready) state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (state_n == CFG) err_n = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         offset_q   <= '0;
         delay_q    <= '0;
         table_q    <= '0;
         dec_q      <= 1'b0;
         din_q      <= '0;
         out_char_q <= '0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
         set_q      <= 1'b0;
         valid_q    <= 1'b0;
         en_q       <= 1'b0;
         ov_q       <= 1'b0;
      end else begin
         state      <= state_n;
         wait_cnt   <= wait_n;
         offset_q   <= offset_n;
         delay_q    <= delay_n;
         table_q    <= table_n;
         dec_q      <= dec_n;
         din_q      <= din_n;
         out_char_q <= out_char_n;
         err_q      <= err_n;
         cnt_q      <= cnt_n;
         set_q      <= (state_n == CFG);
         valid_q    <= (state_n == ISSUE);
         en_q       <= (state_n == WAIT);
         ov_q       <= (state_n == OUT);
      end
   end

   assign in_ready     = (state == IDLE) && !cfg_load;
   assign cfg_ack      = set_q;
   assign out_valid    = ov_q;
   assign out_char     = out_char_q;
   assign err          = err_q;
   assign char_cnt     = cnt_q;
   assign rot.r_set    = set_q;
   assign rot.r_offset = offset_q;
   assign rot.r_delay  = delay_q;
   assign rot.r_idx    = table_q;
   assign rot.r_dec    = dec_q;
   assign rot.r_valid  = valid_q;
   assign rot.r_din    = din_q;
   assign rot.r_en     = en_q;
   assign rot.r_rot    = 1'b0;

endmodule

// File: tb/tb_rotor_seq.sv
// Directed bench for rotor_seq with a behavioural rotor (result = char+1, done 3 cycles after r_valid).
// Expected host results go into a queue that a negedge monitor pops on every out_valid & out_ready.
module tb_rotor_seq;
   localparam int TO = 16;
   localparam int CW = 3;

   typedef struct packed {
      logic [7:0]    ch;
      logic [CW-1:0] cnt;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset_n, cfg_load, cfg_dec, in_valid, out_ready;
   logic [31:0]   cfg_offset, cfg_delay;
   logic [207:0]  cfg_table, ident;
   logic [7:0]    in_char, out_char;
   logic          cfg_ack, in_ready, out_valid, err;
   logic [CW-1:0] char_cnt, exp_cnt;
   bit            rot_dead;
   int            checks = 0;
   int            errors = 0;
   exp_t          sb[$];

   always #5 clk = ~clk;

   rotor_seq_if bus ();

   rotor_seq #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk(clk), .reset_n(reset_n), .cfg_load(cfg_load), .cfg_offset(cfg_offset),
      .cfg_delay(cfg_delay), .cfg_table(cfg_table), .cfg_dec(cfg_dec), .cfg_ack(cfg_ack),
      .in_valid(in_valid), .in_char(in_char), .in_ready(in_ready), .out_valid(out_valid),
      .out_char(out_char), .out_ready(out_ready), .err(err), .char_cnt(char_cnt), .rot(bus)
   );

   task automatic chk(input string name, input logic [207:0] act, input logic [207:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] c);
      in_valid = 1'b1;
      in_char  = c;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic push_letter(input logic [7:0] c);
      exp_t e;
      exp_cnt = exp_cnt + 1'b1;
      e.ch    = c + 8'd1;
      e.cnt   = exp_cnt;
      sb.push_back(e);
   endtask

   task automatic wait_out(input string name, input int limit);
      int n;
      n = 0;
      while (!out_valid && n < limit) begin
         tick();
         n++;
      end
      chk(name, out_valid, 1);
   endtask

   // Rotor model, driven away from the active edge.
   initial begin
      int         dly;
      logic [7:0] d;
      dly = -1;
      d = 8'd0;
      bus.r_done = 1'b0;
      bus.r_dout = 8'd0;
      forever begin
         @(negedge clk);
         bus.r_done = 1'b0;
         if (rot_dead) dly = -1;
         else if (bus.r_valid) begin
            dly = 3;
            d = bus.r_din;
         end else if (dly > 0) begin
            dly--;
            if (dly == 0) begin
               bus.r_done = 1'b1;
               bus.r_dout = d + 8'd1;
            end
         end
      end
   end

   // Scoreboard monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_out actual=%0h expected=none", out_char);
            end else begin
               e = sb.pop_front();
               chk("sb_char", out_char, e.ch);
               chk("sb_cnt", char_cnt, e.cnt);
            end
         end
      end
   end

   initial begin
      int   k, n_en;
      bit   seen_ov;
      reset_n = 1'b0; cfg_load = 1'b0; cfg_dec = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      cfg_offset = '0; cfg_delay = '0; cfg_table = '0; in_char = '0; rot_dead = 1'b0; exp_cnt = '0;
      for (int i = 0; i < 26; i++) ident[207-8*i -: 8] = 8'(65 + i);
      tick(); tick();
      chk("rst_ctl", {cfg_ack, out_valid, err, bus.r_set, bus.r_valid, bus.r_en, bus.r_rot, bus.r_dec}, 0);
      chk("rst_cfg", {bus.r_offset, bus.r_delay}, 0);
      chk("rst_idx", bus.r_idx, 0);
      chk("rst_data", {out_char, bus.r_din, char_cnt}, 0);
      reset_n = 1'b1;
      tick();

      // Configuration handshake
      cfg_table = ident; cfg_delay = 32'd4; cfg_offset = 32'd0; cfg_load = 1'b1;
      #1 chk("cfg_in_ready", in_ready, 0);
      tick();
      cfg_load = 1'b0;
      chk("cfg_pulse", {bus.r_set, cfg_ack}, 2'b11);
      chk("cfg_idx", bus.r_idx, ident);
      chk("cfg_delay", bus.r_delay, 4);
      tick();
      chk("cfg_pulse_end", {bus.r_set, cfg_ack}, 0);
      chk("cfg_rdy", in_ready, 1);

      // Single character 'C' -> 'D'
      send(8'd67); push_letter(8'd67);
      chk("c_issue", {bus.r_valid, bus.r_en, bus.r_din}, {2'b10, 8'd67});
      tick();
      chk("c_en", {bus.r_valid, bus.r_en}, 2'b01);
      n_en = 1; k = 1;
      while (!out_valid && k < 20) begin
         tick();
         k++;
         if (!out_valid && bus.r_en) n_en++;
      end
      chk("c_lat", k, 4);
      chk("c_en_cycles", n_en, 3);
      chk("c_en_off", bus.r_en, 0);
      tick();

      // Bypass of a non-letter
      begin
         exp_t e;
         e.ch = 8'd53; e.cnt = exp_cnt;
         sb.push_back(e);
      end
      send(8'd53);
      chk("byp_out", {out_valid, bus.r_valid, out_char}, {2'b10, 8'd53});
      tick();
      chk("byp_no_rot", {bus.r_valid, bus.r_en}, 0);
      chk("byp_cnt", char_cnt, exp_cnt);

      // Backpressure with a pending 'A'
      out_ready = 1'b0;
      send(8'h58); push_letter(8'h58);
      wait_out("bp_wait", 20);
      in_valid = 1'b1; in_char = 8'h41;
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold", {out_valid, in_ready, out_char}, {2'b10, 8'h59});
         tick();
      end
      out_ready = 1'b1;
      tick();
      chk("bp_rdy", {in_ready, bus.r_valid}, 2'b10);
      tick();
      in_valid = 1'b0;
      push_letter(8'h41);
      chk("bp_acc", {bus.r_valid, bus.r_din}, {1'b1, 8'h41});
      wait_out("bp_a_wait", 20);
      tick();

      // Timeout with a dead rotor
      rot_dead = 1'b1;
      send(8'h51);
      k = 0; seen_ov = 1'b0;
      while (!err && k < 40) begin
         tick();
         k++;
         if (out_valid) seen_ov = 1'b1;
      end
      chk("to_lat", k, 17);
      chk("to_state", {err, out_valid, in_ready, bus.r_en}, 4'b1010);
      chk("to_no_out", seen_ov, 0);
      cfg_offset = 32'd3; cfg_dec = 1'b1; cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
      chk("to_clr", {err, cfg_ack, bus.r_dec}, 3'b011);
      chk("to_off", bus.r_offset, 3);
      tick();
      rot_dead = 1'b0;

      // Reset during WAIT; the late r_done must be ignored
      send(8'h4D); tick(); tick();
      chk("rw_en", bus.r_en, 1);
      reset_n = 1'b0;
      tick();
      chk("rw_ctl", {cfg_ack, out_valid, err, bus.r_set, bus.r_valid, bus.r_en, bus.r_rot, bus.r_dec}, 0);
      chk("rw_cfg", {bus.r_offset, bus.r_delay}, 0);
      chk("rw_idx", bus.r_idx, 0);
      chk("rw_data", {out_char, bus.r_din, char_cnt}, 0);
      reset_n = 1'b1; exp_cnt = '0;
      tick();
      chk("rw_done_ign", {out_valid, bus.r_en}, 0);
      tick();

      // cfg_load and in_valid together in IDLE
      cfg_table = ident; cfg_offset = 32'd5; cfg_dec = 1'b0; cfg_delay = 32'd4;
      cfg_load = 1'b1; in_valid = 1'b1; in_char = 8'h4B;
      #1 chk("col_rdy", in_ready, 0);
      tick();
      cfg_load = 1'b0; in_valid = 1'b0;
      chk("col_cfg", {cfg_ack, bus.r_valid}, 2'b10);
      chk("col_off", bus.r_offset, 5);
      tick();
      chk("col_nochar", {bus.r_valid, in_ready, out_valid}, 3'b010);

      // cfg_load during WAIT is ignored
      send(8'h45); push_letter(8'h45);
      tick();
      cfg_offset = 32'd7; cfg_load = 1'b1;
      tick();
      cfg_load = 1'b0;
      chk("wcfg_ign", {cfg_ack, bus.r_set}, 0);
      chk("wcfg_off", bus.r_offset, 5);
      wait_out("wcfg_wait", 20);
      tick();

      // Counter wrap
      for (int i = 0; i < 9; i++) begin
         send(8'(65 + i)); push_letter(8'(65 + i));
         wait_out("wrap_wait", 20);
         tick();
      end
      chk("wrap_cnt", char_cnt, exp_cnt);
      repeat (3) tick();
      chk("sb_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rotor_seq.md
Name: rotor_seq

Overview:
- Initiator-side sequencer that drives the rotor handshake (set / valid / en / done) on behalf of a host character stream.
- Loads rotor configuration, issues one character per transaction, and paces the rotor while it computes.
- Captures the rotor result and presents it to the host with valid/ready backpressure.
- Sits between the host/UART front end and a single rotor stage; cascaded rotors each get their own rotor_seq.

Parameters:
- TIMEOUT, 64, maximum WAIT cycles before a transaction is abandoned; minimum 2.
- CNT_W, 16, width of the processed-character counter.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset_n  in  1  synchronous active-low reset, sampled on rising edge of clk
- cfg_load  in  1  one-cycle request to load rotor configuration
- cfg_offset  in  32  rotor step offset, 0..25
- cfg_delay  in  32  rotor processing delay
- cfg_table  in  208  substitution table, 26 x 8-bit ASCII; 'A' entry in bits [207:200]
- cfg_dec  in  1  0 = encode, 1 = decode
- cfg_ack  out  1  one-cycle pulse when the configuration is issued to the rotor
- in_valid  in  1  host character valid
- in_char  in  8  host character, ASCII
- in_ready  out  1  high only in IDLE with cfg_load low
- out_valid  out  1  result valid; held until accepted
- out_char  out  8  result character
- out_ready  in  1  host accepts result
- err  out  1  sticky timeout flag; cleared by reset or cfg_load
- char_cnt  out  CNT_W  count of characters delivered through the rotor; wraps
- r_set  out  1  to rotor: configuration strobe
- r_offset  out  32  to rotor: offset
- r_delay  out  32  to rotor: delay
- r_idx  out  208  to rotor: table
- r_dec  out  1  to rotor: direction
- r_valid  out  1  to rotor: character strobe
- r_din  out  8  to rotor: character
- r_en  out  1  to rotor: step/count enable
- r_rot  out  1  to rotor: reserved, driven 0
- r_dout  in  8  from rotor: result
- r_done  in  1  from rotor: result-valid pulse

Behaviour:
- All outputs are registered. Reset values:
  - r_set, r_valid, r_en, cfg_ack, out_valid, err: 0
  - r_rot: 0
  - r_offset, r_delay: 0; r_idx: 0; r_dec: 0
  - r_din, out_char: 0; char_cnt: 0
  - State: IDLE
- FSM states: IDLE, CFG, ISSUE, WAIT, OUT.
- IDLE, cfg_load = 1:
  - Go to CFG, latching the cfg_* inputs into r_offset/r_delay/r_idx/r_dec.
  - cfg_load has priority over in_valid in the same cycle; in_ready is 0 that cycle.
  - cfg_load outside IDLE is ignored, and no cfg_ack is produced.
- CFG (one cycle): r_set = 1 and cfg_ack = 1, err cleared; next state IDLE. r_offset/r_delay/r_idx/r_dec stay stable until the next load.
- IDLE, in_valid & in_ready, in_char in 'A'..'Z' (65..90): latch r_din = in_char, go to ISSUE.
- IDLE, accepted in_char outside 65..90 (bypass):
  - out_char = in_char, go straight to OUT.
  - No rotor activity; char_cnt is not incremented.
- ISSUE (one cycle): r_valid = 1, r_en = 0; next state WAIT, wait counter cleared.
- WAIT:
  - r_en = 1 every cycle; wait counter increments each cycle.
  - r_done = 1: latch out_char = r_dout, char_cnt += 1, go to OUT. r_en is 0 from the next cycle.
  - Wait counter reaches TIMEOUT with no r_done: set err, go to IDLE, character dropped, no out_valid.
  - r_done sampled high in the same cycle as the timeout: r_done wins.
- OUT: out_valid = 1, out_char held stable until out_ready = 1, then IDLE. in_ready is 0 throughout.
- r_done seen in any state other than WAIT is ignored.
- Latency (accept at cycle T):
  - r_valid high at T+1.
  - r_en high from T+2.
  - If r_done is high at cycle D, out_valid is high at D+1.
  - Bypass: out_valid at T+1.
- Throughput: at most one character in flight; a new character is accepted no earlier than the cycle after the out_valid & out_ready handshake.
- Reset mid-operation (any state): next edge returns every output to its reset value and the state to IDLE; any in-flight character is lost.
- char_cnt wraps from 2^CNT_W-1 to 0.

Test Plan:
- Config handshake: reset, cfg_load with identity table "ABC..Z", offset 0, delay 4 -> r_set and cfg_ack each high exactly one cycle; r_idx = table; in_ready high again the next cycle.
- Single character: rotor model returns in_char+1 with done 3 cycles after r_valid; send 'C' (67) -> r_valid with r_din = 67 at T+1, r_en high T+2..done, out_char = 'D' (68), char_cnt = 1.
- Bypass: send '5' (53) -> out_valid at T+1 with out_char = 53; r_valid never asserts; char_cnt unchanged.
- Backpressure: out_ready held 0 for 5 cycles after out_valid -> out_char stable, in_valid ignored; 'A' accepted only after the handshake.
- Timeout: TIMEOUT = 16, rotor model never raises done -> err = 1 after 16 WAIT cycles, no out_valid, IDLE; a subsequent cfg_load clears err.
- Reset and collisions: reset_n low during WAIT -> all outputs at reset values next edge; cfg_load and in_valid in the same IDLE cycle -> config taken, char not accepted; cfg_load during WAIT -> ignored, no cfg_ack.
